// File: rtl/ysyx_25040129_wb_sched.sv
// Writeback scheduler for the RV32E register file: arbitrates EXU/LSU writebacks onto
// the single regfile write port and stalls issue on RAW/WAW hazards via a busy scoreboard.
module ysyx_25040129_wb_sched #(
  parameter int REGS_DIG = 4,
  parameter int XLEN     = 32,
  parameter bit RR_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  input  logic                iss_wb,
  input  logic [REGS_DIG-1:0] iss_rd,
  input  logic [REGS_DIG-1:0] iss_src1,
  input  logic [REGS_DIG-1:0] iss_src2,
  output logic                iss_stall,
  input  logic                exu_valid,
  output logic                exu_ready,
  input  logic [REGS_DIG-1:0] exu_rd,
  input  logic [XLEN-1:0]     exu_data,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [REGS_DIG-1:0] lsu_rd,
  input  logic [XLEN-1:0]     lsu_data,
  output logic [REGS_DIG-1:0] rd,
  output logic                reg_write,
  output logic [XLEN-1:0]     result
);

  localparam int NREGS = 1 << REGS_DIG;

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_next_s;
  logic             rr_last_r;
  logic             exu_gnt_s;
  logic             lsu_gnt_s;
  logic             iss_fire_s;

  // Hazard check: x0 never stalls because busy_r[0] is held at zero
  always_comb begin
    iss_stall = 1'b0;
    if (iss_valid) begin
      iss_stall = busy_r[iss_src1] | busy_r[iss_src2] | (iss_wb & busy_r[iss_rd]);
    end else begin
      iss_stall = 1'b0;
    end
  end

  assign iss_fire_s = iss_valid & ~iss_stall & iss_wb & (iss_rd != {REGS_DIG{1'b0}});

  // Writeback arbitration; rr_last_r=1 means LSU won last, so EXU goes next
  always_comb begin
    exu_gnt_s = 1'b0;
    lsu_gnt_s = 1'b0;
    if (exu_valid && lsu_valid) begin
      if (RR_EN) begin
        exu_gnt_s = rr_last_r;
        lsu_gnt_s = ~rr_last_r;
      end else begin
        lsu_gnt_s = 1'b1;
      end
    end else if (exu_valid) begin
      exu_gnt_s = 1'b1;
    end else if (lsu_valid) begin
      lsu_gnt_s = 1'b1;
    end else begin
      exu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end
  end

  assign exu_ready = exu_gnt_s;
  assign lsu_ready = lsu_gnt_s;

  // Scoreboard next state: an issue set on the same edge as a commit clear wins
  always_comb begin
    busy_next_s    = {NREGS{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      busy_next_s[i] = (iss_fire_s && (iss_rd == REGS_DIG'(i))) |
                       (busy_r[i] & ~(reg_write && (rd == REGS_DIG'(i))));
    end
  end

  // State, arbitration history and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r    <= {NREGS{1'b0}};
      rr_last_r <= 1'b1;
      rd        <= {REGS_DIG{1'b0}};
      reg_write <= 1'b0;
      result    <= {XLEN{1'b0}};
    end else begin
      busy_r <= busy_next_s;
      if (exu_gnt_s) begin
        rr_last_r <= 1'b0;
        rd        <= exu_rd;
        result    <= exu_data;
        reg_write <= (exu_rd != {REGS_DIG{1'b0}});
      end else if (lsu_gnt_s) begin
        rr_last_r <= 1'b1;
        rd        <= lsu_rd;
        result    <= lsu_data;
        reg_write <= (lsu_rd != {REGS_DIG{1'b0}});
      end else begin
        reg_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_wb_sched.sv
// Directed bench: a round-robin instance (a) and a fixed-priority instance (b) share stimulus.
module tb_ysyx_25040129_wb_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid = 1'b0, iss_wb = 1'b0;
  logic [3:0]  iss_rd = 4'd0, iss_src1 = 4'd0, iss_src2 = 4'd0;
  logic        exu_valid = 1'b0, lsu_valid = 1'b0;
  logic [3:0]  exu_rd = 4'd0, lsu_rd = 4'd0;
  logic [31:0] exu_data = 32'd0, lsu_data = 32'd0;

  logic        stall_a, exu_rdy_a, lsu_rdy_a, we_a;
  logic [3:0]  rd_a;
  logic [31:0] res_a;
  logic        stall_b, exu_rdy_b, lsu_rdy_b, we_b;
  logic [3:0]  rd_b;
  logic [31:0] res_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ysyx_25040129_wb_sched #(.REGS_DIG(4), .XLEN(32), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_wb(iss_wb), .iss_rd(iss_rd),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_stall(stall_a),
    .exu_valid(exu_valid), .exu_ready(exu_rdy_a), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_rdy_a), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rd(rd_a), .reg_write(we_a), .result(res_a));

  ysyx_25040129_wb_sched #(.REGS_DIG(4), .XLEN(32), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_wb(iss_wb), .iss_rd(iss_rd),
    .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_stall(stall_b),
    .exu_valid(exu_valid), .exu_ready(exu_rdy_b), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_rdy_b), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rd(rd_b), .reg_write(we_b), .result(res_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    iss_valid = 1'b0; iss_wb = 1'b0; iss_rd = 4'd0; iss_src1 = 4'd0; iss_src2 = 4'd0;
    exu_valid = 1'b0; lsu_valid = 1'b0; exu_rd = 4'd0; lsu_rd = 4'd0;
    exu_data = 32'd0; lsu_data = 32'd0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    vectors++; if (we_a !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", we_a); end
    vectors++; if (rd_a !== 4'd0) begin miscompares++; $display("FAIL rst_rd: got %h want 0", rd_a); end
    vectors++; if (res_a !== 32'd0) begin miscompares++; $display("FAIL rst_result: got %h want 0", res_a); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    // issue x5 while EXU writes x3 so both busy and reg_write are live
    iss_valid = 1'b1; iss_wb = 1'b1; iss_rd = 4'd5;
    exu_valid = 1'b1; exu_rd = 4'd3; exu_data = 32'h0000_0033;
    tick();
    idle();
    iss_valid = 1'b1; iss_src1 = 4'd5;
    #1;
    vectors++; if (stall_a !== 1'b1) begin miscompares++; $display("FAIL pre_rst_stall: got %b want 1", stall_a); end
    vectors++; if (we_a !== 1'b1) begin miscompares++; $display("FAIL pre_rst_we: got %b want 1", we_a); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (we_a !== 1'b0) begin miscompares++; $display("FAIL async_rst_we: got %b want 0", we_a); end
    vectors++; if (stall_a !== 1'b0) begin miscompares++; $display("FAIL async_rst_busy: got %b want 0", stall_a); end
    vectors++; if (rd_a !== 4'd0) begin miscompares++; $display("FAIL async_rst_rd: got %h want 0", rd_a); end
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_raw;
    do_reset();
    iss_valid = 1'b1; iss_wb = 1'b1; iss_rd = 4'd5;
    #1;
    vectors++; if (stall_a !== 1'b0) begin miscompares++; $display("FAIL raw_issue_stall: got %b want 0", stall_a); end
    tick();
    iss_wb = 1'b0; iss_rd = 4'd0; iss_src1 = 4'd5;
    #1;
    vectors++; if (stall_a !== 1'b1) begin miscompares++; $display("FAIL raw_stall0: got %b want 1", stall_a); end
    tick();
    vectors++; if (stall_a !== 1'b1) begin miscompares++; $display("FAIL raw_stall1: got %b want 1", stall_a); end
    exu_valid = 1'b1; exu_rd = 4'd5; exu_data = 32'hDEAD_BEEF;
    #1;
    vectors++; if (exu_rdy_a !== 1'b1) begin miscompares++; $display("FAIL raw_exu_ready: got %b want 1", exu_rdy_a); end
    vectors++; if (lsu_rdy_a !== 1'b0) begin miscompares++; $display("FAIL raw_lsu_ready: got %b want 0", lsu_rdy_a); end
    tick();
    exu_valid = 1'b0;
    #1;
    vectors++; if (we_a !== 1'b1) begin miscompares++; $display("FAIL raw_we: got %b want 1", we_a); end
    vectors++; if (rd_a !== 4'd5) begin miscompares++; $display("FAIL raw_rd: got %h want 5", rd_a); end
    vectors++; if (res_a !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL raw_result: got %h want deadbeef", res_a); end
    vectors++; if (stall_a !== 1'b1) begin miscompares++; $display("FAIL raw_stall_wb: got %b want 1", stall_a); end
    tick();
    vectors++; if (we_a !== 1'b0) begin miscompares++; $display("FAIL raw_we_drop: got %b want 0", we_a); end
    vectors++; if (stall_a !== 1'b0) begin miscompares++; $display("FAIL raw_stall_drop: got %b want 0", stall_a); end
    idle();
  endtask

  task automatic test_arbitration;
    logic exp_e;
    do_reset();
    exu_valid = 1'b1; exu_rd = 4'd1; exu_data = 32'hAAAA_0001;
    lsu_valid = 1'b1; lsu_rd = 4'd2; lsu_data = 32'h5555_0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_e = (i % 2 == 0);
      vectors++; if (exu_rdy_a !== exp_e) begin miscompares++; $display("FAIL rr_exu_ready[%0d]: got %b want %b", i, exu_rdy_a, exp_e); end
      vectors++; if (lsu_rdy_a !== ~exp_e) begin miscompares++; $display("FAIL rr_lsu_ready[%0d]: got %b want %b", i, lsu_rdy_a, ~exp_e); end
      vectors++; if (exu_rdy_b !== 1'b0) begin miscompares++; $display("FAIL fp_exu_ready[%0d]: got %b want 0", i, exu_rdy_b); end
      vectors++; if (lsu_rdy_b !== 1'b1) begin miscompares++; $display("FAIL fp_lsu_ready[%0d]: got %b want 1", i, lsu_rdy_b); end
      tick();
      vectors++; if (rd_a !== (exp_e ? 4'd1 : 4'd2)) begin miscompares++; $display("FAIL rr_rd[%0d]: got %h want %h", i, rd_a, (exp_e ? 4'd1 : 4'd2)); end
      vectors++; if (res_a !== (exp_e ? 32'hAAAA_0001 : 32'h5555_0002)) begin miscompares++; $display("FAIL rr_result[%0d]: got %h", i, res_a); end
      vectors++; if (we_a !== 1'b1) begin miscompares++; $display("FAIL rr_we[%0d]: got %b want 1", i, we_a); end
      vectors++; if (rd_b !== 4'd2 || res_b !== 32'h5555_0002) begin miscompares++; $display("FAIL fp_out[%0d]: got rd %h data %h want 2 55550002", i, rd_b, res_b); end
    end
    idle();
    tick();
    vectors++; if (we_a !== 1'b0) begin miscompares++; $display("FAIL arb_idle_we: got %b want 0", we_a); end
    vectors++; if (rd_a !== 4'd2) begin miscompares++; $display("FAIL arb_hold_rd: got %h want 2", rd_a); end
  endtask

  task automatic test_x0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      iss_valid = 1'b1; iss_wb = 1'b1; iss_rd = 4'd0;
      #1;
      vectors++; if (stall_a !== 1'b0) begin miscompares++; $display("FAIL x0_stall[%0d]: got %b want 0", i, stall_a); end
      tick();
    end
    idle();
    lsu_valid = 1'b1; lsu_rd = 4'd0; lsu_data = 32'h0000_1234;
    #1;
    vectors++; if (lsu_rdy_a !== 1'b1) begin miscompares++; $display("FAIL x0_lsu_ready: got %b want 1", lsu_rdy_a); end
    tick();
    idle();
    vectors++; if (we_a !== 1'b0) begin miscompares++; $display("FAIL x0_we: got %b want 0", we_a); end
    vectors++; if (res_a !== 32'h0000_1234) begin miscompares++; $display("FAIL x0_result: got %h want 1234", res_a); end
  endtask

  task automatic test_same_edge;
    do_reset();
    exu_valid = 1'b1; exu_rd = 4'd7; exu_data = 32'h0000_0777;
    tick();
    idle();
    iss_valid = 1'b1; iss_wb = 1'b1; iss_rd = 4'd7;
    #1;
    vectors++; if (we_a !== 1'b1 || rd_a !== 4'd7) begin miscompares++; $display("FAIL se_commit: got we %b rd %h want 1 7", we_a, rd_a); end
    vectors++; if (stall_a !== 1'b0) begin miscompares++; $display("FAIL se_issue_stall: got %b want 0", stall_a); end
    tick();
    #1;
    vectors++; if (stall_a !== 1'b1) begin miscompares++; $display("FAIL se_waw_stall: got %b want 1", stall_a); end
    iss_wb = 1'b0; iss_rd = 4'd0; iss_src2 = 4'd7;
    #1;
    vectors++; if (stall_a !== 1'b1) begin miscompares++; $display("FAIL se_raw_stall: got %b want 1", stall_a); end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_arbitration();
    test_x0();
    test_same_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
